// File: rtl/lsu_mem_stage_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package lsu_mem_stage_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned F3_W   = 3;
   localparam int unsigned REG_W  = 5;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_e;

   // funct3 encodings for loads and stores
   localparam logic [F3_W-1:0] F3_LB  = 3'b000;
   localparam logic [F3_W-1:0] F3_LH  = 3'b001;
   localparam logic [F3_W-1:0] F3_LW  = 3'b010;
   localparam logic [F3_W-1:0] F3_LBU = 3'b100;
   localparam logic [F3_W-1:0] F3_LHU = 3'b101;
   localparam logic [F3_W-1:0] F3_SB  = 3'b000;
   localparam logic [F3_W-1:0] F3_SH  = 3'b001;
   localparam logic [F3_W-1:0] F3_SW  = 3'b010;

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Data-memory request/acknowledge bus between the LSU (master) and memory (slave).
interface lsu_mem_stage_if;
   import lsu_mem_stage_pkg::*;

   logic              mem_req;
   logic              mem_we;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [STRB_W-1:0] mem_wstrb;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_ack, mem_rdata
   );

endinterface

// File: rtl/lsu_mem_stage_align.sv
// lsu_align: store lane/strobe generation, load extraction/extension, misalign detect.
// Sub-word accesses exist only when LSU_SUBWORD_EN is defined; otherwise every
// access is a word access on a word-aligned address.
module lsu_align
   import lsu_mem_stage_pkg::*;
(
   input  logic [DATA_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_store_data,
   input  logic [F3_W-1:0]   i_funct3,
   input  logic [1:0]        i_ld_offset,
   input  logic [F3_W-1:0]   i_ld_funct3,
   input  logic [DATA_W-1:0] i_rdata,
   output logic [DATA_W-1:0] o_addr_c,
   output logic [DATA_W-1:0] o_wdata_c,
   output logic [STRB_W-1:0] o_wstrb_c,
   output logic              o_misalign_c,
   output logic [DATA_W-1:0] o_ld_data_c
);

`ifdef LSU_SUBWORD_EN
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_unused;

   assign w_unused = i_funct3[2];

   // store lane replication, byte enables and alignment check
   always_comb begin
      o_addr_c     = i_addr;
      o_wdata_c    = i_store_data;
      o_wstrb_c    = 4'b1111;
      o_misalign_c = 1'b0;
      case (i_funct3[1:0])
         2'b00: begin
            o_wdata_c = {4{i_store_data[7:0]}};
            o_wstrb_c = 4'b0001 << i_addr[1:0];
         end
         2'b01: begin
            o_wdata_c    = {2{i_store_data[15:0]}};
            o_wstrb_c    = 4'b0011 << i_addr[1:0];
            o_misalign_c = i_addr[0];
         end
         default: o_misalign_c = |i_addr[1:0];
      endcase
   end

   assign w_byte = i_rdata[{i_ld_offset, 3'b000} +: 8];
   assign w_half = i_rdata[{i_ld_offset[1], 4'b0000} +: 16];

   // load lane extraction with sign/zero extension
   always_comb begin
      o_ld_data_c = i_rdata;
      case (i_ld_funct3)
         F3_LB:   o_ld_data_c = {{24{w_byte[7]}}, w_byte};
         F3_LH:   o_ld_data_c = {{16{w_half[15]}}, w_half};
         F3_LBU:  o_ld_data_c = {24'd0, w_byte};
         F3_LHU:  o_ld_data_c = {16'd0, w_half};
         default: o_ld_data_c = i_rdata;
      endcase
   end
`else
   logic w_unused;

   assign w_unused     = ^{i_addr[1:0], i_funct3, i_ld_offset, i_ld_funct3};
   assign o_addr_c     = {i_addr[DATA_W-1:2], 2'b00};
   assign o_wdata_c    = i_store_data;
   assign o_wstrb_c    = 4'b1111;
   assign o_misalign_c = 1'b0;
   assign o_ld_data_c  = i_rdata;
`endif

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage LSU: captures EX results, runs one memory transaction at a
// time and emits a one-cycle write-back pulse. Optional sub-word support is
// enabled by defining LSU_SUBWORD_EN.
module lsu_mem_stage
   import lsu_mem_stage_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 255
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic              valid_ex,
   input  logic              alu_ready,
   input  logic [DATA_W-1:0] alu_result_ex,
   input  logic [DATA_W-1:0] store_data_ex,
   input  logic              mem_read_ex,
   input  logic              mem_write_ex,
   input  logic [F3_W-1:0]   funct3_ex,
   input  logic [REG_W-1:0]  rd_ex,
   input  logic              reg_write_ex,
   output logic              data_ready_mem,
   lsu_mem_stage_if.master   mem,
   output logic              valid_wb,
   output logic [DATA_W-1:0] result_wb,
   output logic [REG_W-1:0]  rd_wb,
   output logic              reg_write_wb,
   output logic              bus_err,
   output logic              misalign
);

   localparam int unsigned CNT_W  = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
   localparam int unsigned TMO_M1 = (ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1;

   state_e            r_state, w_state_nxt;
   logic              r_ready;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_req, w_req_nxt;
   logic              r_we, w_we_nxt;
   logic [DATA_W-1:0] r_addr, w_addr_nxt;
   logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
   logic [STRB_W-1:0] r_wstrb, w_wstrb_nxt;
   logic [F3_W-1:0]   r_f3, w_f3_nxt;
   logic [REG_W-1:0]  r_rd, w_rd_nxt;
   logic              r_valid_wb, w_valid_nxt;
   logic [DATA_W-1:0] r_result_wb, w_result_nxt;
   logic [REG_W-1:0]  r_rd_wb, w_rd_wb_nxt;
   logic              r_regw_wb, w_regw_nxt;
   logic              r_bus_err, w_err_nxt;
   logic              r_misalign, w_mis_nxt;

   logic              w_capture, w_is_mem, w_start, w_ack, w_timeout;
   logic [DATA_W-1:0] w_addr_c, w_wdata_c, w_ld_data_c;
   logic [STRB_W-1:0] w_wstrb_c;
   logic              w_misalign_c;

   lsu_align u_align (
      .i_addr       (alu_result_ex),
      .i_store_data (store_data_ex),
      .i_funct3     (funct3_ex),
      .i_ld_offset  (r_addr[1:0]),
      .i_ld_funct3  (r_f3),
      .i_rdata      (mem.mem_rdata),
      .o_addr_c     (w_addr_c),
      .o_wdata_c    (w_wdata_c),
      .o_wstrb_c    (w_wstrb_c),
      .o_misalign_c (w_misalign_c),
      .o_ld_data_c  (w_ld_data_c)
   );

   assign w_capture = (r_state == S_IDLE) && valid_ex && alu_ready;
   assign w_is_mem  = mem_read_ex || mem_write_ex;
   assign w_start   = w_capture && w_is_mem && !w_misalign_c;
   assign w_ack     = (r_state == S_BUSY) && mem.mem_ack;
   // an ack in the timeout cycle takes priority over the abort
   assign w_timeout = (r_state == S_BUSY) && !mem.mem_ack && (ACK_TIMEOUT != 0)
                      && (r_cnt == CNT_W'(TMO_M1));

   // state register
   always_ff @(posedge clk) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_start) w_state_nxt = S_BUSY;
         S_BUSY: if (w_ack || w_timeout) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // next values of bus, write-back and bookkeeping registers
   always_comb begin
      w_cnt_nxt    = r_cnt;
      w_req_nxt    = r_req;
      w_we_nxt     = r_we;
      w_addr_nxt   = r_addr;
      w_wdata_nxt  = r_wdata;
      w_wstrb_nxt  = r_wstrb;
      w_f3_nxt     = r_f3;
      w_rd_nxt     = r_rd;
      w_valid_nxt  = 1'b0;
      w_result_nxt = r_result_wb;
      w_rd_wb_nxt  = r_rd_wb;
      w_regw_nxt   = 1'b0;
      w_err_nxt    = 1'b0;
      w_mis_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_capture && !w_is_mem) begin
               w_valid_nxt  = 1'b1;
               w_result_nxt = alu_result_ex;
               w_rd_wb_nxt  = rd_ex;
               w_regw_nxt   = reg_write_ex;
            end else if (w_capture && w_misalign_c) begin
               w_valid_nxt  = 1'b1;
               w_mis_nxt    = 1'b1;
               w_result_nxt = '0;
               w_rd_wb_nxt  = rd_ex;
            end else if (w_start) begin
               w_req_nxt   = 1'b1;
               w_we_nxt    = !mem_read_ex;
               w_addr_nxt  = w_addr_c;
               w_wdata_nxt = w_wdata_c;
               w_wstrb_nxt = w_wstrb_c;
               w_f3_nxt    = funct3_ex;
               w_rd_nxt    = rd_ex;
               w_cnt_nxt   = '0;
            end
         end
         S_BUSY: begin
            if (w_ack) begin
               w_req_nxt    = 1'b0;
               w_valid_nxt  = 1'b1;
               w_rd_wb_nxt  = r_rd;
               w_regw_nxt   = !r_we;
               w_result_nxt = r_we ? '0 : w_ld_data_c;
            end else if (w_timeout) begin
               w_req_nxt    = 1'b0;
               w_valid_nxt  = 1'b1;
               w_err_nxt    = 1'b1;
               w_rd_wb_nxt  = r_rd;
               w_result_nxt = '0;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: w_req_nxt = 1'b0;
      endcase
   end

   // registered outputs and datapath
   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_ready     <= 1'b1;
         r_cnt       <= '0;
         r_req       <= 1'b0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_f3        <= '0;
         r_rd        <= '0;
         r_valid_wb  <= 1'b0;
         r_result_wb <= '0;
         r_rd_wb     <= '0;
         r_regw_wb   <= 1'b0;
         r_bus_err   <= 1'b0;
         r_misalign  <= 1'b0;
      end else begin
         r_ready     <= (w_state_nxt == S_IDLE);
         r_cnt       <= w_cnt_nxt;
         r_req       <= w_req_nxt;
         r_we        <= w_we_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_wstrb     <= w_wstrb_nxt;
         r_f3        <= w_f3_nxt;
         r_rd        <= w_rd_nxt;
         r_valid_wb  <= w_valid_nxt;
         r_result_wb <= w_result_nxt;
         r_rd_wb     <= w_rd_wb_nxt;
         r_regw_wb   <= w_regw_nxt;
         r_bus_err   <= w_err_nxt;
         r_misalign  <= w_mis_nxt;
      end
   end

   assign data_ready_mem = r_ready;
   assign mem.mem_req    = r_req;
   assign mem.mem_we     = r_we;
   assign mem.mem_addr   = r_addr;
   assign mem.mem_wdata  = r_wdata;
   assign mem.mem_wstrb  = r_wstrb;
   assign valid_wb       = r_valid_wb;
   assign result_wb      = r_result_wb;
   assign rd_wb          = r_rd_wb;
   assign reg_write_wb   = r_regw_wb;
   assign bus_err        = r_bus_err;
   assign misalign       = r_misalign;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage (ACK_TIMEOUT = 4); expectations follow
// LSU_SUBWORD_EN when it is defined.
module tb_lsu_mem_stage;
   import lsu_mem_stage_pkg::*;

   logic        clk;
   logic        rstn;
   logic        valid_ex, alu_ready, mem_read_ex, mem_write_ex, reg_write_ex;
   logic [31:0] alu_result_ex, store_data_ex;
   logic [2:0]  funct3_ex;
   logic [4:0]  rd_ex;
   logic        data_ready_mem, valid_wb, reg_write_wb, bus_err, misalign;
   logic [31:0] result_wb;
   logic [4:0]  rd_wb;

   lsu_mem_stage_if mem_if ();

   lsu_mem_stage #(.ACK_TIMEOUT(4)) dut (
      .clk           (clk),
      .rstn          (rstn),
      .valid_ex      (valid_ex),
      .alu_ready     (alu_ready),
      .alu_result_ex (alu_result_ex),
      .store_data_ex (store_data_ex),
      .mem_read_ex   (mem_read_ex),
      .mem_write_ex  (mem_write_ex),
      .funct3_ex     (funct3_ex),
      .rd_ex         (rd_ex),
      .reg_write_ex  (reg_write_ex),
      .data_ready_mem(data_ready_mem),
      .mem           (mem_if),
      .valid_wb      (valid_wb),
      .result_wb     (result_wb),
      .rd_wb         (rd_wb),
      .reg_write_wb  (reg_write_wb),
      .bus_err       (bus_err),
      .misalign      (misalign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rd_en;
      logic        wr_en;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] sd;
      logic [4:0]  rd;
      logic        regw;
      int          ack_at;   // BUSY cycle in which memory acks (0 = never)
      logic [31:0] rdata;
      int          busy;     // expected number of mem_req cycles
      logic [31:0] e_addr;
      logic        e_we;
      logic [31:0] e_wdata;
      logic [3:0]  e_wstrb;
      logic [31:0] e_result;
      logic        e_regw;
      logic        e_err;
      logic        e_mis;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cur     = -1;

   function automatic vec_t mk(
      input logic rd_en, input logic wr_en, input logic [2:0] f3,
      input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
      input logic regw, input int ack_at, input logic [31:0] rdata, input int busy,
      input logic [31:0] e_addr, input logic e_we, input logic [31:0] e_wdata,
      input logic [3:0] e_wstrb, input logic [31:0] e_result, input logic e_regw,
      input logic e_err, input logic e_mis);
      vec_t v;
      v.rd_en = rd_en; v.wr_en = wr_en; v.f3 = f3; v.a = a; v.sd = sd; v.rd = rd;
      v.regw = regw; v.ack_at = ack_at; v.rdata = rdata; v.busy = busy;
      v.e_addr = e_addr; v.e_we = e_we; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb;
      v.e_result = e_result; v.e_regw = e_regw; v.e_err = e_err; v.e_mis = e_mis;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (case %0d): got %h, expected %h", nm, cur, act, exp);
      end
   endtask

   task automatic drive_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [4:0] rd, input logic regw);
      valid_ex = 1'b1; alu_ready = 1'b1;
      mem_read_ex = rd_en; mem_write_ex = wr_en; funct3_ex = f3;
      alu_result_ex = a; store_data_ex = sd; rd_ex = rd; reg_write_ex = regw;
   endtask

   // one full transaction: capture, BUSY phase with ack at v.ack_at, write-back pulse
   task automatic run_vec(input vec_t v);
      @(negedge clk);
      drive_op(v.rd_en, v.wr_en, v.f3, v.a, v.sd, v.rd, v.regw);
      chk("ready_before_capture", {31'd0, data_ready_mem}, 32'd1);
      @(negedge clk);
      valid_ex = 1'b0;
      for (int k = 1; k <= v.busy; k++) begin
         chk("mem_req_busy", {31'd0, mem_if.mem_req}, 32'd1);
         chk("ready_busy", {31'd0, data_ready_mem}, 32'd0);
         chk("mem_addr", mem_if.mem_addr, v.e_addr);
         chk("mem_we", {31'd0, mem_if.mem_we}, {31'd0, v.e_we});
         if (v.e_we) begin
            chk("mem_wdata", mem_if.mem_wdata, v.e_wdata);
            chk("mem_wstrb", {28'd0, mem_if.mem_wstrb}, {28'd0, v.e_wstrb});
         end
         if (k == v.ack_at) begin
            mem_if.mem_ack   = 1'b1;
            mem_if.mem_rdata = v.rdata;
         end
         @(negedge clk);
         mem_if.mem_ack   = 1'b0;
         mem_if.mem_rdata = 32'h0;
      end
      chk("valid_wb", {31'd0, valid_wb}, 32'd1);
      chk("result_wb", result_wb, v.e_result);
      chk("rd_wb", {27'd0, rd_wb}, {27'd0, v.rd});
      chk("reg_write_wb", {31'd0, reg_write_wb}, {31'd0, v.e_regw});
      chk("bus_err", {31'd0, bus_err}, {31'd0, v.e_err});
      chk("misalign", {31'd0, misalign}, {31'd0, v.e_mis});
      chk("mem_req_done", {31'd0, mem_if.mem_req}, 32'd0);
      chk("ready_done", {31'd0, data_ready_mem}, 32'd1);
      @(negedge clk);
      chk("valid_wb_pulse", {31'd0, valid_wb}, 32'd0);
      chk("pulse_flags", {30'd0, bus_err, misalign}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //                rd wr f3     a             sd            rd regw ack rdata         busy e_addr        we e_wdata       strb     e_result      regw err mis
      vecs[0]  = mk(0, 0, 3'b000, 32'h0000_1234, 32'h0,         5, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         4'h0,    32'h0000_1234, 1, 0, 0);
      vecs[1]  = mk(0, 0, 3'b111, 32'hFFFF_0000, 32'h1,        31, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         4'h0,    32'hFFFF_0000, 0, 0, 0);
      vecs[2]  = mk(1, 0, F3_LW,  32'h0000_0100, 32'h0,         7, 1, 3, 32'hDEAD_BEEF, 3, 32'h0000_0100, 0, 32'h0,         4'h0,    32'hDEAD_BEEF, 1, 0, 0);
      vecs[3]  = mk(1, 0, F3_LW,  32'h0000_0104, 32'h0,         8, 1, 1, 32'h1234_5678, 1, 32'h0000_0104, 0, 32'h0,         4'h0,    32'h1234_5678, 1, 0, 0);
      vecs[4]  = mk(0, 1, F3_SW,  32'h0000_0200, 32'hCAFE_F00D, 9, 0, 2, 32'hFFFF_FFFF, 2, 32'h0000_0200, 1, 32'hCAFE_F00D, 4'b1111, 32'h0,         0, 0, 0);
      vecs[12] = mk(1, 0, F3_LW,  32'h0000_0300, 32'h0,        12, 1, 0, 32'h0,         4, 32'h0000_0300, 0, 32'h0,         4'h0,    32'h0,         0, 1, 0);
      vecs[13] = mk(1, 0, F3_LW,  32'h0000_0304, 32'h0,        13, 1, 4, 32'h0BAD_F00D, 4, 32'h0000_0304, 0, 32'h0,         4'h0,    32'h0BAD_F00D, 1, 0, 0);
      vecs[14] = mk(1, 1, F3_LW,  32'h0000_0308, 32'h1111_1111,14, 1, 1, 32'h7654_3210, 1, 32'h0000_0308, 0, 32'h0,         4'h0,    32'h7654_3210, 1, 0, 0);
`ifdef LSU_SUBWORD_EN
      vecs[5]  = mk(0, 1, F3_SB,  32'h0000_0103, 32'h1234_56AB, 2, 0, 1, 32'h0,         1, 32'h0000_0103, 1, 32'hABAB_ABAB, 4'b1000, 32'h0,         0, 0, 0);
      vecs[6]  = mk(1, 0, F3_LB,  32'h0000_0102, 32'h0,         3, 1, 2, 32'h0080_0000, 2, 32'h0000_0102, 0, 32'h0,         4'h0,    32'hFFFF_FF80, 1, 0, 0);
      vecs[7]  = mk(1, 0, F3_LBU, 32'h0000_0102, 32'h0,         4, 1, 1, 32'h0080_0000, 1, 32'h0000_0102, 0, 32'h0,         4'h0,    32'h0000_0080, 1, 0, 0);
      vecs[8]  = mk(1, 0, F3_LH,  32'h0000_0101, 32'h0,         6, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0,         4'h0,    32'h0,         0, 0, 1);
      vecs[9]  = mk(1, 0, F3_LH,  32'h0000_0102, 32'h0,        10, 1, 1, 32'h8001_0000, 1, 32'h0000_0102, 0, 32'h0,         4'h0,    32'hFFFF_8001, 1, 0, 0);
      vecs[10] = mk(1, 0, F3_LHU, 32'h0000_0102, 32'h0,        11, 1, 1, 32'h8001_0000, 1, 32'h0000_0102, 0, 32'h0,         4'h0,    32'h0000_8001, 1, 0, 0);
      vecs[11] = mk(0, 1, F3_SH,  32'h0000_0102, 32'h0000_BEEF, 1, 0, 1, 32'h0,         1, 32'h0000_0102, 1, 32'hBEEF_BEEF, 4'b1100, 32'h0,         0, 0, 0);
      vecs[15] = mk(0, 1, F3_SW,  32'h0000_0202, 32'h0102_0304,15, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         4'h0,    32'h0,         0, 0, 1);
      vecs[16] = mk(1, 0, F3_LB,  32'h0000_0103, 32'h0,        16, 1, 1, 32'h7F00_0000, 1, 32'h0000_0103, 0, 32'h0,         4'h0,    32'h0000_007F, 1, 0, 0);
`else
      vecs[5]  = mk(0, 1, F3_SB,  32'h0000_0103, 32'h1234_56AB, 2, 0, 1, 32'h0,         1, 32'h0000_0100, 1, 32'h1234_56AB, 4'b1111, 32'h0,         0, 0, 0);
      vecs[6]  = mk(1, 0, F3_LB,  32'h0000_0102, 32'h0,         3, 1, 2, 32'h0080_0000, 2, 32'h0000_0100, 0, 32'h0,         4'h0,    32'h0080_0000, 1, 0, 0);
      vecs[7]  = mk(1, 0, F3_LBU, 32'h0000_0102, 32'h0,         4, 1, 1, 32'h0080_0000, 1, 32'h0000_0100, 0, 32'h0,         4'h0,    32'h0080_0000, 1, 0, 0);
      vecs[8]  = mk(1, 0, F3_LH,  32'h0000_0101, 32'h0,         6, 1, 1, 32'h55AA_55AA, 1, 32'h0000_0100, 0, 32'h0,         4'h0,    32'h55AA_55AA, 1, 0, 0);
      vecs[9]  = mk(1, 0, F3_LH,  32'h0000_0102, 32'h0,        10, 1, 1, 32'h8001_0000, 1, 32'h0000_0100, 0, 32'h0,         4'h0,    32'h8001_0000, 1, 0, 0);
      vecs[10] = mk(1, 0, F3_LHU, 32'h0000_0102, 32'h0,        11, 1, 1, 32'h8001_0000, 1, 32'h0000_0100, 0, 32'h0,         4'h0,    32'h8001_0000, 1, 0, 0);
      vecs[11] = mk(0, 1, F3_SH,  32'h0000_0102, 32'h0000_BEEF, 1, 0, 1, 32'h0,         1, 32'h0000_0100, 1, 32'h0000_BEEF, 4'b1111, 32'h0,         0, 0, 0);
      vecs[15] = mk(0, 1, F3_SW,  32'h0000_0202, 32'h0102_0304,15, 0, 1, 32'h0,         1, 32'h0000_0200, 1, 32'h0102_0304, 4'b1111, 32'h0,         0, 0, 0);
      vecs[16] = mk(1, 0, F3_LB,  32'h0000_0103, 32'h0,        16, 1, 1, 32'h7F00_0000, 1, 32'h0000_0100, 0, 32'h0,         4'h0,    32'h7F00_0000, 1, 0, 0);
`endif

      rstn = 1'b0;
      valid_ex = 1'b0; alu_ready = 1'b0; mem_read_ex = 1'b0; mem_write_ex = 1'b0;
      alu_result_ex = 32'h0; store_data_ex = 32'h0; funct3_ex = 3'b0; rd_ex = 5'd0;
      reg_write_ex = 1'b0;
      mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'h0;
      repeat (3) @(negedge clk);

      // reset values
      chk("rst_ready", {31'd0, data_ready_mem}, 32'd1);
      chk("rst_req_we", {30'd0, mem_if.mem_req, mem_if.mem_we}, 32'd0);
      chk("rst_addr", mem_if.mem_addr, 32'h0);
      chk("rst_wdata", mem_if.mem_wdata, 32'h0);
      chk("rst_wstrb", {28'd0, mem_if.mem_wstrb}, 32'd0);
      chk("rst_wb", {27'd0, valid_wb, reg_write_wb, bus_err, misalign, 1'b0}, 32'd0);
      chk("rst_result", result_wb, 32'h0);
      chk("rst_rd", {27'd0, rd_wb}, 32'd0);
      rstn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         cur = i;
         run_vec(vecs[i]);
      end

      // non-memory ops back to back, one capture per cycle
      cur = 100;
      @(negedge clk);
      drive_op(0, 0, 3'b000, 32'h0000_0011, 32'h0, 5'd1, 1'b1);
      @(negedge clk);
      chk("b2b_ready0", {31'd0, data_ready_mem}, 32'd1);
      chk("b2b_res0", {valid_wb, 26'd0, rd_wb} ^ 32'h0, {1'b1, 26'd0, 5'd1});
      chk("b2b_val0", result_wb, 32'h0000_0011);
      drive_op(0, 0, 3'b000, 32'h0000_0022, 32'h0, 5'd2, 1'b0);
      @(negedge clk);
      chk("b2b_ready1", {31'd0, data_ready_mem}, 32'd1);
      chk("b2b_res1", {valid_wb, reg_write_wb, 25'd0, rd_wb}, {1'b1, 1'b0, 25'd0, 5'd2});
      chk("b2b_val1", result_wb, 32'h0000_0022);
      drive_op(0, 0, 3'b000, 32'h0000_0033, 32'h0, 5'd3, 1'b1);
      @(negedge clk);
      valid_ex = 1'b0;
      chk("b2b_res2", {valid_wb, reg_write_wb, 25'd0, rd_wb}, {1'b1, 1'b1, 25'd0, 5'd3});
      chk("b2b_val2", result_wb, 32'h0000_0033);
      @(negedge clk);
      chk("b2b_idle", {31'd0, valid_wb}, 32'd0);

      // zero-wait load, then capture in the cycle right after the ack
      cur = 101;
      drive_op(1, 0, F3_LW, 32'h0000_0400, 32'h0, 5'd20, 1'b1);
      @(negedge clk);
      valid_ex = 1'b0;
      chk("ack_next_req", {31'd0, mem_if.mem_req}, 32'd1);
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hA5A5_0001;
      @(negedge clk);
      mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'h0;
      chk("ack_next_wb", {31'd0, valid_wb}, 32'd1);
      chk("ack_next_ldval", result_wb, 32'hA5A5_0001);
      chk("ack_next_ready", {31'd0, data_ready_mem}, 32'd1);
      drive_op(0, 0, 3'b000, 32'h0000_0777, 32'h0, 5'd3, 1'b1);
      @(negedge clk);
      valid_ex = 1'b0;
      chk("ack_next_alu_wb", {valid_wb, reg_write_wb, mem_if.mem_req, 24'd0, rd_wb},
          {1'b1, 1'b1, 1'b0, 24'd0, 5'd3});
      chk("ack_next_alu_val", result_wb, 32'h0000_0777);

      // reset asserted mid-BUSY abandons the request with no write-back
      cur = 102;
      @(negedge clk);
      drive_op(1, 0, F3_LW, 32'h0000_0500, 32'h0, 5'd21, 1'b1);
      @(negedge clk);
      valid_ex = 1'b0;
      chk("rstbusy_req1", {31'd0, mem_if.mem_req}, 32'd1);
      @(negedge clk);
      chk("rstbusy_req2", {31'd0, mem_if.mem_req}, 32'd1);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("rstbusy_req_low", {31'd0, mem_if.mem_req}, 32'd0);
      chk("rstbusy_ready", {31'd0, data_ready_mem}, 32'd1);
      for (int c = 0; c < 6; c++) begin
         chk("rstbusy_no_wb", {29'd0, valid_wb, bus_err, mem_if.mem_req}, 32'd0);
         @(negedge clk);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
